// File: rtl/hazard_fwd_ctrl_if.sv
// D-stage decode bundle and hazard/forwarding responses exchanged between
// the pipeline datapath (master) and the hazard controller (slave).
interface hazard_fwd_ctrl_if #(
  parameter int RA_W = 5,
  parameter int TN_W = 2
);
  logic            pipe_en;
  logic [RA_W-1:0] d_rs;
  logic [RA_W-1:0] d_rt;
  logic [TN_W-1:0] d_rs_tuse;
  logic [TN_W-1:0] d_rt_tuse;
  logic [RA_W-1:0] d_a3;
  logic [TN_W-1:0] d_tnew;
  logic [1:0]      d_md_op;
  logic            d_md_use;
  logic            stall;
  logic [1:0]      d_fwd_rs;
  logic [1:0]      d_fwd_rt;
  logic [1:0]      e_fwd_rs;
  logic [1:0]      e_fwd_rt;
  logic            md_busy;

  modport master (
    output pipe_en, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_a3, d_tnew, d_md_op, d_md_use,
    input  stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, md_busy
  );

  modport slave (
    input  pipe_en, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_a3, d_tnew, d_md_op, d_md_use,
    output stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, md_busy
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline: shadows in-flight
// destinations and Tnew per stage, drives forwarding selects, stall and MD interlock.
module hazard_fwd_ctrl #(
  parameter int RA_W     = 5,
  parameter int TN_W     = 2,
  parameter int CNT_W    = 4,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  hazard_fwd_ctrl_if.slave hz
);

  localparam logic [1:0] SRC_RF = 2'd0;
  localparam logic [1:0] SRC_E  = 2'd1;
  localparam logic [1:0] SRC_M  = 2'd2;
  localparam logic [1:0] SRC_W  = 2'd3;

  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  logic [RA_W-1:0]  e_rs_q,   e_rs_d;
  logic [RA_W-1:0]  e_rt_q,   e_rt_d;
  logic [RA_W-1:0]  e_a3_q,   e_a3_d;
  logic [TN_W-1:0]  e_tnew_q, e_tnew_d;
  logic [RA_W-1:0]  m_a3_q,   m_a3_d;
  logic [TN_W-1:0]  m_tnew_q, m_tnew_d;
  logic [RA_W-1:0]  w_a3_q,   w_a3_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic stall;
  logic md_busy;
  logic advance;

  // Only the nearest in-flight producer of r matters; an older stage holds stale data.
  function automatic logic port_stall(
    input logic [RA_W-1:0] r,
    input logic [TN_W-1:0] tuse,
    input logic [RA_W-1:0] ea3,
    input logic [TN_W-1:0] etn,
    input logic [RA_W-1:0] ma3,
    input logic [TN_W-1:0] mtn
  );
    if (r == '0)  return 1'b0;
    if (r == ea3) return (tuse < etn);
    if (r == ma3) return (tuse < mtn);
    return 1'b0;
  endfunction

  function automatic logic [1:0] d_sel(
    input logic [RA_W-1:0] r,
    input logic [RA_W-1:0] ea3,
    input logic [TN_W-1:0] etn,
    input logic [RA_W-1:0] ma3,
    input logic [TN_W-1:0] mtn,
    input logic [RA_W-1:0] wa3
  );
    if (r == '0)  return SRC_RF;
    if (r == ea3) return (etn == '0) ? SRC_E : SRC_RF;
    if (r == ma3) return (mtn == '0) ? SRC_M : SRC_RF;
    if (r == wa3) return SRC_W;
    return SRC_RF;
  endfunction

  function automatic logic [1:0] e_sel(
    input logic [RA_W-1:0] r,
    input logic [RA_W-1:0] ma3,
    input logic [TN_W-1:0] mtn,
    input logic [RA_W-1:0] wa3
  );
    if (r == '0)  return SRC_RF;
    if (r == ma3) return (mtn == '0) ? SRC_M : SRC_RF;
    if (r == wa3) return SRC_W;
    return SRC_RF;
  endfunction

  function automatic logic [TN_W-1:0] sat_dec(input logic [TN_W-1:0] v);
    return (v == '0) ? '0 : v - TN_W'(1);
  endfunction

  assign md_busy = (md_cnt_q != '0);

  assign stall = port_stall(hz.d_rs, hz.d_rs_tuse, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q)
               | port_stall(hz.d_rt, hz.d_rt_tuse, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q)
               | (hz.d_md_use & md_busy);

  assign advance = hz.pipe_en & ~stall;

  assign hz.stall    = stall;
  assign hz.md_busy  = md_busy;
  assign hz.d_fwd_rs = d_sel(hz.d_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
  assign hz.d_fwd_rt = d_sel(hz.d_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
  assign hz.e_fwd_rs = e_sel(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
  assign hz.e_fwd_rt = e_sel(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);

  always_comb begin
    e_rs_d   = e_rs_q;
    e_rt_d   = e_rt_q;
    e_a3_d   = e_a3_q;
    e_tnew_d = e_tnew_q;
    m_a3_d   = m_a3_q;
    m_tnew_d = m_tnew_q;
    w_a3_d   = w_a3_q;
    if (hz.pipe_en) begin
      if (stall) begin
        e_rs_d   = '0;
        e_rt_d   = '0;
        e_a3_d   = '0;
        e_tnew_d = '0;
      end else begin
        e_rs_d   = hz.d_rs;
        e_rt_d   = hz.d_rt;
        e_a3_d   = hz.d_a3;
        e_tnew_d = hz.d_tnew;
      end
      m_a3_d   = e_a3_q;
      m_tnew_d = sat_dec(e_tnew_q);
      w_a3_d   = m_a3_q;
    end
  end

  // The MD unit keeps running while the pipeline waits on memory.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (advance && hz.d_md_op == MD_MULT) begin
      md_cnt_d = MULT_CNT;
    end else if (advance && hz.d_md_op == MD_DIV) begin
      md_cnt_d = DIV_CNT;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_a3_q   <= '0;
      e_tnew_q <= '0;
      m_a3_q   <= '0;
      m_tnew_q <= '0;
      w_a3_q   <= '0;
      md_cnt_q <= '0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: each vector queues its hand-derived outputs,
// a negedge monitor pops and compares them.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic reset_n;

  hazard_fwd_ctrl_if #(.RA_W(5), .TN_W(2)) hz ();

  hazard_fwd_ctrl #(
    .RA_W(5), .TN_W(2), .CNT_W(4), .MULT_LAT(5), .DIV_LAT(10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, exp completion");
    $fatal(1, "watchdog");
  end

  // Vector: reset_n, pipe_en, rs, rt, rs_tuse, rt_tuse, a3, tnew, md_op, md_use,
  // then expected stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, md_busy.
  task automatic v(input string nm, input int rst, input int pe,
                   input int rs, input int rt, input int rsu, input int rtu,
                   input int a3, input int tn, input int md, input int mu,
                   input int st, input int dfs, input int dft,
                   input int efs, input int eft, input int busy);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n      = 1'(rst);
    hz.pipe_en   = 1'(pe);
    hz.d_rs      = 5'(rs);
    hz.d_rt      = 5'(rt);
    hz.d_rs_tuse = 2'(rsu);
    hz.d_rt_tuse = 2'(rtu);
    hz.d_a3      = 5'(a3);
    hz.d_tnew    = 2'(tn);
    hz.d_md_op   = 2'(md);
    hz.d_md_use  = 1'(mu);
    e.name = nm;
    e.exp  = {1'(st), 2'(dfs), 2'(dft), 2'(efs), 2'(eft), 1'(busy)};
    sb.push_back(e);
  endtask

  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hz.stall, hz.d_fwd_rs, hz.d_fwd_rt, hz.e_fwd_rs, hz.e_fwd_rt, hz.md_busy};
        n_chk++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got st=%0b dfs=%0d dft=%0d efs=%0d eft=%0d busy=%0b, exp st=%0b dfs=%0d dft=%0d efs=%0d eft=%0d busy=%0b",
                      e.name, act[9], act[8:7], act[6:5], act[4:3], act[2:1], act[0],
                      e.exp[9], e.exp[8:7], e.exp[6:5], e.exp[4:3], e.exp[2:1], e.exp[0]);
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    hz.pipe_en   = 1'b1;
    hz.d_rs      = '0;
    hz.d_rt      = '0;
    hz.d_rs_tuse = '0;
    hz.d_rt_tuse = '0;
    hz.d_a3      = '0;
    hz.d_tnew    = '0;
    hz.d_md_op   = '0;
    hz.d_md_use  = 1'b0;

    //  name            rst pe rs rt ru tu a3 tn md mu   st dfs dft efs eft bz
    v("rst",            0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    v("idle",           1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // lw $1 then addu using $1 one cycle later
    v("t1_lw",          1, 1, 0, 0, 0, 0, 1, 2, 0, 0,   0, 0, 0, 0, 0, 0);
    v("t1_stall",       1, 1, 1, 3, 1, 1, 4, 1, 0, 0,   1, 0, 0, 0, 0, 0);
    v("t1_resume",      1, 1, 1, 3, 1, 1, 4, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    v("t1_efwd",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 0);
    // addu $2 then beq on $2; rt=$4 comes from W meanwhile
    v("t2_addu",        1, 1, 0, 0, 0, 0, 2, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    v("t2_stall",       1, 1, 2, 4, 0, 0, 0, 0, 0, 0,   1, 0, 3, 0, 0, 0);
    v("t2_mfwd",        1, 1, 2, 4, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0);
    // jal then jr $31
    v("t3_jal",         1, 1, 0, 0, 0, 0,31, 0, 0, 0,   0, 0, 0, 3, 0, 0);
    v("t3_jr",          1, 1,31, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    v("rs_eq_rt",       1, 1,31,31, 0, 0, 0, 0, 0, 0,   0, 2, 2, 2, 0, 0);
    v("e_wfwd",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 3, 0);
    // back-to-back writers of $5: E is nearest, then pipe_en=0 holds
    v("lw5",            1, 1, 0, 0, 0, 0, 5, 2, 0, 0,   0, 0, 0, 0, 0, 0);
    v("addu5",          1, 1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    v("near_e",         1, 1, 5, 5, 0, 2, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    v("hold_a",         1, 0, 5, 5, 0, 2, 0, 0, 0, 0,   0, 2, 2, 0, 0, 0);
    v("hold_b",         1, 0, 5, 5, 0, 2, 0, 0, 0, 0,   0, 2, 2, 0, 0, 0);
    // unready M producer must not fall through to an older W copy
    v("lw6",            1, 1, 0, 0, 0, 0, 6, 2, 0, 0,   0, 0, 0, 0, 0, 0);
    v("lw6b",           1, 1, 0, 0, 0, 0, 6, 2, 0, 0,   0, 0, 0, 0, 0, 0);
    v("e_unrdy_prep",   1, 1, 6, 0, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    v("m_unready",      1, 1, 6, 0, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    v("e_wfwd6",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 0);
    // div then mfhi: exactly DIV_LAT stall cycles
    v("t4_div",         1, 1, 0, 0, 0, 0, 0, 0, 2, 1,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      v("t4_busy",      1, 1, 0, 0, 0, 0, 7, 0, 0, 1,   1, 0, 0, 0, 0, 1);
    v("t4_done",        1, 1, 0, 0, 0, 0, 7, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    // mult counts down even with the pipeline frozen
    v("mult",           1, 1, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      v("mult_busy",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    v("mult_done",      1, 1, 0, 0, 0, 0, 0, 0, 3, 1,   0, 0, 0, 0, 0, 0);
    v("md_rsvd",        1, 1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    // async reset while div is busy
    v("t6_div",         1, 1, 0, 0, 0, 0, 0, 0, 2, 0,   0, 0, 0, 0, 0, 0);
    v("t6_busy",        1, 1, 0, 0, 0, 0, 7, 0, 0, 1,   1, 0, 0, 0, 0, 1);
    v("t6_reset",       0, 1, 0, 0, 0, 0, 7, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    v("t6_release",     1, 1, 0, 0, 0, 0, 7, 0, 0, 1,   0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending, exp 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
